// File: rtl/uart_wb_core_if.sv
// Wishbone register-bus bundle for uart_wb_core.
// The master drives address, write data, direction and strobe; the slave returns
// read data and a one-cycle acknowledge.
interface uart_wb_core_if;
   logic [2:0] wb_addr;
   logic [7:0] wb_data_in;
   logic [7:0] wb_data_out;
   logic       wb_we;
   logic       wb_stb;
   logic       wb_ack;

   modport master (output wb_addr, wb_data_in, wb_we, wb_stb, input wb_data_out, wb_ack);
   modport slave  (input wb_addr, wb_data_in, wb_we, wb_stb, output wb_data_out, wb_ack);
endinterface

// File: rtl/uart_wb_core.sv
// Full-duplex UART with a Wishbone register file, TX/RX FIFOs, a 16-bit baud
// divider (16 ticks per bit) and a registered level interrupt.
// Optional feature: define UART_PARITY_EN to add a parity bit between data and
// stop (even parity, odd when CTRL[2] is set).
//
// state    | meaning (shared encoding for TX and RX FSMs)
// S_IDLE   | line idle, waiting for FIFO data (TX) or a low sample (RX)
// S_START  | start bit; RX re-checks the line at tick 8
// S_DATA   | DATA_BITS payload bits, LSB first
// S_PARITY | parity bit (only reachable with UART_PARITY_EN)
// S_STOP   | stop bit
module uart_wb_core #(
   parameter int          DATA_BITS  = 8,
   parameter int          FIFO_DEPTH = 16,
   parameter logic [15:0] DIV_RESET  = 16'd6
) (
   input  logic          clk,
   input  logic          reset_n,
   uart_wb_core_if.slave wb,
   output logic          tx_bit,
   input  logic          rx_bit,
   output logic          irq
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;
   localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

   logic ack_q, xfer, wr, rd, div_wr, status_rd;
   logic [15:0] div_q, tick_cnt;
   logic tick;
   logic ctrl_rx_en, ctrl_tx_en, ctrl_odd;
   logic [7:0] rdata;

   // A held strobe only transfers while ack is low, giving one access per two cycles.
   assign xfer      = wb.wb_stb & ~ack_q;
   assign wr        = xfer & wb.wb_we;
   assign rd        = xfer & ~wb.wb_we;
   assign div_wr    = wr && (wb.wb_addr == 3'd2 || wb.wb_addr == 3'd3);
   assign status_rd = rd && (wb.wb_addr == 3'd4);
   assign tick      = (tick_cnt == div_q);

   logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
   logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
   logic [AW:0] tx_wp, tx_rp, rx_wp, rx_rp;
   logic tx_empty, tx_full, tx_push, tx_pop, rx_empty, rx_full, rx_push, rx_pop;
   logic [DATA_BITS-1:0] tx_head;

   assign tx_empty = (tx_wp == tx_rp);
   assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
   assign rx_empty = (rx_wp == rx_rp);
   assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
   assign tx_push  = wr && (wb.wb_addr == 3'd0) && !tx_full;
   assign rx_pop   = rd && (wb.wb_addr == 3'd1) && !rx_empty;
   assign tx_head  = tx_mem[tx_rp[AW-1:0]];

   logic [2:0] tx_state, rx_state;
   logic [3:0] tx_phase, rx_phase, tx_bitn, rx_bitn;
   logic [DATA_BITS-1:0] tx_shift, rx_shift;
   logic tx_busy, rx_meta, rx_s, rx_end, rx_ovr, rx_ferr, rx_perr;

   assign tx_busy = (tx_state != S_IDLE);
   // A new frame starts straight out of STOP when data is waiting, so no idle bit is inserted.
   assign tx_pop  = tick && !div_wr && !tx_empty &&
                    (tx_state == S_IDLE || (tx_state == S_STOP && tx_phase == 4'd15));
   assign rx_end  = tick && !div_wr && (rx_state == S_STOP) && (rx_phase == 4'd15);
   assign rx_push = rx_end && rx_s && !rx_full;

`ifdef UART_PARITY_EN
   logic tx_par, perr_set;
   assign perr_set = tick && !div_wr && (rx_state == S_PARITY) && (rx_phase == 4'd15) &&
                     (rx_s != (^rx_shift ^ ctrl_odd));
   // Parity error flag, cleared by a STATUS read unless a new error lands the same cycle.
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) rx_perr <= 1'b0;
      else          rx_perr <= perr_set | (rx_perr & ~status_rd);
`else
   assign ctrl_odd = 1'b0;
   assign rx_perr  = 1'b0;
`endif

   // Register writes: divider bytes and control bits.
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         div_q      <= DIV_RESET;
         ctrl_rx_en <= 1'b0;
         ctrl_tx_en <= 1'b0;
`ifdef UART_PARITY_EN
         ctrl_odd   <= 1'b0;
`endif
      end else if (wr) begin
         case (wb.wb_addr)
            3'd2: div_q[7:0]  <= wb.wb_data_in;
            3'd3: div_q[15:8] <= wb.wb_data_in;
            3'd5: begin
               ctrl_rx_en <= wb.wb_data_in[0];
               ctrl_tx_en <= wb.wb_data_in[1];
`ifdef UART_PARITY_EN
               ctrl_odd   <= wb.wb_data_in[2];
`endif
            end
            default: ;
         endcase
      end

   // Baud tick: counts 0..div, restarts on any divider write.
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n)               tick_cnt <= '0;
      else if (div_wr || tick)    tick_cnt <= '0;
      else                        tick_cnt <= tick_cnt + 16'd1;

   // FIFO pointers; storage below is not reset since empty pointers hide it.
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         tx_wp <= '0; tx_rp <= '0; rx_wp <= '0; rx_rp <= '0;
      end else begin
         if (tx_push) tx_wp <= tx_wp + 1'b1;
         if (tx_pop)  tx_rp <= tx_rp + 1'b1;
         if (rx_push) rx_wp <= rx_wp + 1'b1;
         if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      end

   // FIFO storage writes.
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp[AW-1:0]] <= wb.wb_data_in[DATA_BITS-1:0];
      if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_shift;
   end

   // TX frame sequencer; tx_bit is registered so reset forces the line high immediately.
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         tx_state <= S_IDLE; tx_phase <= '0; tx_bitn <= '0; tx_shift <= '0; tx_bit <= 1'b1;
`ifdef UART_PARITY_EN
         tx_par   <= 1'b0;
`endif
      end else if (div_wr) begin
         tx_phase <= '0;
      end else if (tick) begin
         if (tx_pop) begin
            tx_state <= S_START; tx_phase <= '0; tx_shift <= tx_head; tx_bit <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par   <= ^tx_head ^ ctrl_odd;
`endif
         end else if (tx_state != S_IDLE) begin
            if (tx_phase != 4'd15) tx_phase <= tx_phase + 4'd1;
            else begin
               tx_phase <= '0;
               case (tx_state)
                  S_START: begin tx_state <= S_DATA; tx_bitn <= '0; tx_bit <= tx_shift[0]; end
                  S_DATA:
                     if (tx_bitn == LAST_BIT) begin
`ifdef UART_PARITY_EN
                        tx_state <= S_PARITY; tx_bit <= tx_par;
`else
                        tx_state <= S_STOP;   tx_bit <= 1'b1;
`endif
                     end else begin
                        tx_bitn  <= tx_bitn + 4'd1;
                        tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
                        tx_bit   <= tx_shift[1];
                     end
                  S_PARITY: begin tx_state <= S_STOP; tx_bit <= 1'b1; end
                  default:  begin tx_state <= S_IDLE; tx_bit <= 1'b1; end
               endcase
            end
         end
      end

   // Two-flop synchroniser for the asynchronous serial input.
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin rx_meta <= 1'b1; rx_s <= 1'b1; end
      else          begin rx_meta <= rx_bit; rx_s <= rx_meta; end

   // RX frame sequencer: validate start at tick 8, then sample every 16 ticks at bit centre.
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         rx_state <= S_IDLE; rx_phase <= '0; rx_bitn <= '0; rx_shift <= '0;
      end else if (div_wr) begin
         rx_phase <= '0;
      end else if (tick) begin
         case (rx_state)
            S_IDLE: if (!rx_s) begin rx_state <= S_START; rx_phase <= '0; end
            S_START:
               if (rx_phase == 4'd7) begin
                  rx_phase <= '0; rx_bitn <= '0;
                  rx_state <= rx_s ? S_IDLE : S_DATA;
               end else rx_phase <= rx_phase + 4'd1;
            default:
               if (rx_phase != 4'd15) rx_phase <= rx_phase + 4'd1;
               else begin
                  rx_phase <= '0;
                  case (rx_state)
                     S_DATA: begin
                        rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
                        if (rx_bitn == LAST_BIT)
`ifdef UART_PARITY_EN
                           rx_state <= S_PARITY;
`else
                           rx_state <= S_STOP;
`endif
                        else rx_bitn <= rx_bitn + 4'd1;
                     end
                     S_PARITY: rx_state <= S_STOP;
                     default:  rx_state <= S_IDLE;
                  endcase
               end
         endcase
      end

   // Sticky error flags; a STATUS read clears them unless a new event lands the same cycle.
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin rx_ovr <= 1'b0; rx_ferr <= 1'b0; end
      else begin
         rx_ovr  <= (rx_end & rx_s & rx_full) | (rx_ovr & ~status_rd);
         rx_ferr <= (rx_end & ~rx_s) | (rx_ferr & ~status_rd);
      end

   // Read data mux; unmapped addresses read as zero.
   always_comb begin
      rdata = 8'h00;
      case (wb.wb_addr)
         3'd1: rdata = rx_empty ? 8'h00 : 8'(rx_mem[rx_rp[AW-1:0]]);
         3'd2: rdata = div_q[7:0];
         3'd3: rdata = div_q[15:8];
         3'd4: rdata = {1'b0, tx_busy, rx_perr, rx_ferr, rx_ovr, tx_full, tx_empty, ~rx_empty};
         3'd5: rdata = {5'b0, ctrl_odd, ctrl_tx_en, ctrl_rx_en};
         default: rdata = 8'h00;
      endcase
   end

   // Bus acknowledge and read data, both valid for the single ack cycle.
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin ack_q <= 1'b0; wb.wb_data_out <= 8'h00; end
      else begin
         ack_q          <= xfer;
         wb.wb_data_out <= rd ? rdata : 8'h00;
      end

   assign wb.wb_ack = ack_q;

   // Registered level interrupt.
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) irq <= 1'b0;
      else          irq <= (ctrl_rx_en & ~rx_empty) | (ctrl_tx_en & tx_empty & ~tx_busy);
endmodule

// File: tb/tb_uart_wb_core.sv
// Directed bench for uart_wb_core: register access, TX framing, loopback,
// overrun, false start, framing error, parity (when UART_PARITY_EN) and reset.
module tb_uart_wb_core;
   localparam int BIT = 112;            // clk per bit with the reset divider of 6

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic rx_drv = 1'b1;
   logic loop_en = 1'b0;
   logic tx_bit, irq, rx_line;
   logic [7:0] rd_val;
   int checks = 0;
   int errors = 0;
`ifdef UART_PARITY_EN
   logic par_flip = 1'b0;
`endif

   uart_wb_core_if wbi ();

   assign rx_line = loop_en ? tx_bit : rx_drv;

   uart_wb_core dut (
      .clk     (clk),
      .reset_n (reset_n),
      .wb      (wbi),
      .tx_bit  (tx_bit),
      .rx_bit  (rx_line),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   initial begin
      repeat (90000) @(posedge clk);
      $display("FAIL watchdog: observed no finish, expected finish before 90000 cycles");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wb_write(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      wbi.wb_addr = a; wbi.wb_data_in = d; wbi.wb_we = 1'b1; wbi.wb_stb = 1'b1;
      @(posedge clk);
      @(negedge clk);
      wbi.wb_stb = 1'b0; wbi.wb_we = 1'b0;
   endtask

   task automatic wb_read(input logic [2:0] a, output logic [7:0] d);
      @(negedge clk);
      wbi.wb_addr = a; wbi.wb_we = 1'b0; wbi.wb_stb = 1'b1;
      @(posedge clk);
      @(negedge clk);
      d = wbi.wb_data_out;
      wbi.wb_stb = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
      logic [7:0] v;
      wb_read(a, v);
      chk(tag, {8'h00, v}, {8'h00, exp});
   endtask

   task automatic send_frame(input logic [7:0] d, input bit stop_ok);
      rx_drv = 1'b0; repeat (BIT) @(posedge clk);
      for (int i = 0; i < 8; i++) begin rx_drv = d[i]; repeat (BIT) @(posedge clk); end
`ifdef UART_PARITY_EN
      rx_drv = ^d ^ par_flip; repeat (BIT) @(posedge clk);
`endif
      if (stop_ok) begin
         rx_drv = 1'b1; repeat (BIT) @(posedge clk);
      end else begin
         rx_drv = 1'b0; repeat (72) @(posedge clk);
         rx_drv = 1'b1; repeat (2 * BIT) @(posedge clk);
      end
      rx_drv = 1'b1; repeat (BIT) @(posedge clk);
   endtask

   // exp[0] is the start bit; exp[1] must be 1 so the first bit length can be measured.
   task automatic check_tx_frame(input string tag, input logic [10:0] exp, input int nbits,
                                 input int bitlen);
      int n;
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(posedge clk); #1;
         if (tx_bit === 1'b0) seen = 1'b1;
      end
      chk({tag, " start seen"}, {15'b0, seen}, 16'd1);
      if (!seen) return;
      n = 0;
      while (tx_bit === 1'b0 && n < 1000) begin @(posedge clk); #1; n++; end
      chk({tag, " start length"}, 16'(n), 16'(bitlen));
      repeat (bitlen / 2) @(posedge clk);
      #1;
      chk($sformatf("%s bit 1", tag), {15'b0, tx_bit}, {15'b0, exp[1]});
      for (int i = 2; i < nbits; i++) begin
         repeat (bitlen) @(posedge clk);
         #1;
         chk($sformatf("%s bit %0d", tag, i), {15'b0, tx_bit}, {15'b0, exp[i]});
      end
   endtask

   initial begin
      logic [10:0] frame;
      int nbits;
      wbi.wb_addr = 3'd0; wbi.wb_data_in = 8'h00; wbi.wb_we = 1'b0; wbi.wb_stb = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset tx_bit", {15'b0, tx_bit}, 16'd1);
      chk("reset ack", {15'b0, wbi.wb_ack}, 16'd0);
      chk("reset data_out", {8'h00, wbi.wb_data_out}, 16'd0);
      chk("reset irq", {15'b0, irq}, 16'd0);
      @(negedge clk); reset_n = 1'b1;

      rd_chk("status after reset", 3'd4, 8'h02);
      rd_chk("div_lo after reset", 3'd2, 8'h06);
      rd_chk("div_hi after reset", 3'd3, 8'h00);
      rd_chk("ctrl after reset", 3'd5, 8'h00);
      rd_chk("rxdata empty", 3'd1, 8'h00);
      rd_chk("unmapped addr 7", 3'd7, 8'h00);

      // Control register and TX-idle interrupt
      wb_write(3'd5, 8'h07);
`ifdef UART_PARITY_EN
      rd_chk("ctrl readback", 3'd5, 8'h07);
`else
      rd_chk("ctrl readback", 3'd5, 8'h03);
`endif
      @(posedge clk); #1;
      chk("irq tx idle", {15'b0, irq}, 16'd1);
      wb_write(3'd5, 8'h00);
      @(posedge clk); #1;
      chk("irq disabled", {15'b0, irq}, 16'd0);

      // Held strobe gives one transfer every two cycles
      @(negedge clk);
      wbi.wb_addr = 3'd2; wbi.wb_we = 1'b0; wbi.wb_stb = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk($sformatf("held stb ack %0d", i), {15'b0, wbi.wb_ack}, (i % 2 == 0) ? 16'd1 : 16'd0);
         if (i % 2 == 0) chk("held stb data", {8'h00, wbi.wb_data_out}, 16'h0006);
      end
      @(negedge clk); wbi.wb_stb = 1'b0;

      // TX 0x41 framing at 112 clk per bit
      wb_write(3'd2, 8'h06);
      wb_write(3'd0, 8'h41);
`ifdef UART_PARITY_EN
      frame = {1'b1, 1'b0, 8'h41, 1'b0}; nbits = 11;
`else
      frame = {1'b0, 1'b1, 8'h41, 1'b0}; nbits = 10;
`endif
      check_tx_frame("tx 41", frame, nbits, BIT);
      repeat (100) @(posedge clk);
      rd_chk("status after tx", 3'd4, 8'h02);

      // tx_busy visible mid-frame
      wb_write(3'd0, 8'h55);
      repeat (20) @(posedge clk);
      rd_chk("status tx busy", 3'd4, 8'h42);
      repeat (12 * BIT) @(posedge clk);

      // Loopback of three bytes and RX interrupt
      loop_en = 1'b1;
      wb_write(3'd0, 8'h3C);
      wb_write(3'd0, 8'hA5);
      wb_write(3'd0, 8'h0F);
      repeat (3 * 11 * BIT + 500) @(posedge clk);
      wb_write(3'd5, 8'h01);
      @(posedge clk); #1;
      chk("irq rx data", {15'b0, irq}, 16'd1);
      rd_chk("loop byte 0", 3'd1, 8'h3C);
      rd_chk("loop byte 1", 3'd1, 8'hA5);
      rd_chk("loop byte 2", 3'd1, 8'h0F);
      rd_chk("status after loop", 3'd4, 8'h02);
      chk("irq rx drained", {15'b0, irq}, 16'd0);
      wb_write(3'd5, 8'h00);
      loop_en = 1'b0;

      // 17 frames with no reads: 16 kept, overrun set then cleared by read
      for (int i = 0; i < 17; i++) send_frame(8'(8'h10 + i), 1'b1);
      repeat (200) @(posedge clk);
      rd_chk("status overrun", 3'd4, 8'h0B);
      rd_chk("status overrun cleared", 3'd4, 8'h03);
      for (int i = 0; i < 16; i++) begin
         wb_read(3'd1, rd_val);
         chk($sformatf("rx fifo entry %0d", i), {8'h00, rd_val}, 16'(8'h10 + i));
      end
      rd_chk("rxdata after drain", 3'd1, 8'h00);
      rd_chk("status after drain", 3'd4, 8'h02);

      // Short low glitch is a false start
      rx_drv = 1'b0; repeat (21) @(posedge clk);
      rx_drv = 1'b1; repeat (400) @(posedge clk);
      rd_chk("status after glitch", 3'd4, 8'h02);

      // Stop bit sampled low: framing error, byte discarded
      send_frame(8'h5A, 1'b0);
      repeat (400) @(posedge clk);
      rd_chk("status frame err", 3'd4, 8'h12);
      rd_chk("rxdata after frame err", 3'd1, 8'h00);
      rd_chk("status frame err cleared", 3'd4, 8'h02);

`ifdef UART_PARITY_EN
      // Even parity of 0x07 is 1; a flipped parity bit flags an error but keeps the byte
      wb_write(3'd0, 8'h07);
      check_tx_frame("tx 07 parity", {1'b1, 1'b1, 8'h07, 1'b0}, 11, BIT);
      repeat (200) @(posedge clk);
      par_flip = 1'b1;
      send_frame(8'h66, 1'b1);
      par_flip = 1'b0;
      repeat (200) @(posedge clk);
      rd_chk("status parity err", 3'd4, 8'h23);
      rd_chk("rxdata parity byte", 3'd1, 8'h66);
      rd_chk("status parity cleared", 3'd4, 8'h02);
`endif

      // Divider 0: one tick per clk, 16 clk per bit
      wb_write(3'd2, 8'h00);
      rd_chk("div_lo zero", 3'd2, 8'h00);
      wb_write(3'd0, 8'h41);
      check_tx_frame("tx div0", frame, nbits, 16);
      repeat (200) @(posedge clk);

      // Reset in the middle of a TX frame
      wb_write(3'd2, 8'h0A);
      wb_write(3'd0, 8'h00);
      wb_write(3'd0, 8'h11);
      repeat (300) @(posedge clk);
      #1;
      chk("tx low mid frame", {15'b0, tx_bit}, 16'd0);
      @(negedge clk); #2;
      reset_n = 1'b0;
      #1;
      chk("tx high on reset", {15'b0, tx_bit}, 16'd1);
      repeat (3) @(posedge clk);
      @(negedge clk); reset_n = 1'b1;
      rd_chk("status after mid reset", 3'd4, 8'h02);
      rd_chk("div_lo after mid reset", 3'd2, 8'h06);
      rd_chk("div_hi after mid reset", 3'd3, 8'h00);
      repeat (300) @(posedge clk);
      #1;
      chk("tx idle after reset", {15'b0, tx_bit}, 16'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
